// File: rtl/trb_frame_arb_mux_pkg.sv
// Shared types and constants for the turbo-decoder frame arbiter/mux.
// FIFO words are packed as {sop, eop, data}; offsets below are relative to bit DW.
package trb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    localparam int MAX_NUM_CH   = 16;
    localparam int WORD_EOP_OFS = 0;
    localparam int WORD_SOP_OFS = 1;
    localparam int WORD_CTRL_W  = 2;

    function automatic int chw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trb_frame_fifo.sv
// One decoder channel: show-ahead RAM FIFO with fill count, complete-frame count
// and sticky overflow / framing error flags.
module trb_frame_fifo
    import trb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic          wr_sop,
    input  logic          wr_eop,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_sop,
    output logic          rd_eop,
    output logic          rd_nempty,
    output logic          frame_avail,
    output logic          err_overflow,
    output logic          err_framing
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = DW + WORD_CTRL_W;
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d, frame_cnt_q, frame_cnt_d;
    logic          ready_q, ready_d, in_frame_q, in_frame_d;
    logic          ovf_q, ovf_d, frm_q, frm_d;
    logic          wr_fire_s, rd_eop_fire_s;
    logic [WW-1:0] rd_word_s;

    always_comb begin
        wr_fire_s     = wr_valid & ready_q;
        rd_word_s     = mem[rd_ptr_q];
        rd_eop_fire_s = rd_en & rd_word_s[DW+WORD_EOP_OFS];
        wr_ptr_d      = wr_fire_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d      = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        case ({wr_fire_s, rd_en})
            2'b10:   fill_d = fill_q + CNT_ONE;
            2'b01:   fill_d = fill_q - CNT_ONE;
            default: fill_d = fill_q;
        endcase

        case ({wr_fire_s & wr_eop, rd_eop_fire_s})
            2'b10:   frame_cnt_d = frame_cnt_q + CNT_ONE;
            2'b01:   frame_cnt_d = frame_cnt_q - CNT_ONE;
            default: frame_cnt_d = frame_cnt_q;
        endcase

        // Ready is registered so the input side never sees a combinational path.
        ready_d = (fill_d != CNT_FULL);

        if (wr_fire_s) begin
            if (wr_eop) begin
                in_frame_d = 1'b0;
            end else if (wr_sop) begin
                in_frame_d = 1'b1;
            end else begin
                in_frame_d = in_frame_q;
            end
        end else begin
            in_frame_d = in_frame_q;
        end

        ovf_d = ovf_q | (wr_valid & ~ready_q);
        frm_d = frm_q | (wr_fire_s & (wr_sop ~^ in_frame_q));
    end

    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem[wr_ptr_q] <= {wr_sop, wr_eop, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            fill_q      <= {(AW+1){1'b0}};
            frame_cnt_q <= {(AW+1){1'b0}};
            ready_q     <= 1'b1;
            in_frame_q  <= 1'b0;
            ovf_q       <= 1'b0;
            frm_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            frame_cnt_q <= frame_cnt_d;
            ready_q     <= ready_d;
            in_frame_q  <= in_frame_d;
            ovf_q       <= ovf_d;
            frm_q       <= frm_d;
        end
    end

    assign wr_ready     = ready_q;
    assign rd_data      = rd_word_s[DW-1:0];
    assign rd_sop       = rd_word_s[DW+WORD_SOP_OFS];
    assign rd_eop       = rd_word_s[DW+WORD_EOP_OFS];
    assign rd_nempty    = (fill_q != {(AW+1){1'b0}});
    assign frame_avail  = (frame_cnt_q != {(AW+1){1'b0}});
    assign err_overflow = ovf_q;
    assign err_framing  = frm_q;

endmodule

// File: rtl/trb_frame_arb_mux.sv
// N-channel frame-aware output mux: per-channel frame FIFOs, frame-granular
// work-conserving round-robin, one registered valid/ready output stage.
module trb_frame_arb_mux
    import trb_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  DW     = 8,
    parameter int  DEPTH  = 1024,
    localparam int CHW    = chw_of(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH*DW-1:0] st_data_in,
    input  logic [NUM_CH-1:0]    st_valid_in,
    input  logic [NUM_CH-1:0]    st_sop_in,
    input  logic [NUM_CH-1:0]    st_eop_in,
    output logic [NUM_CH-1:0]    st_ready_out,
    input  logic                 st_ready_in,
    output logic [DW-1:0]        st_data_out,
    output logic                 st_valid_out,
    output logic                 st_sop_out,
    output logic                 st_eop_out,
    output logic [CHW-1:0]       st_ch_out,
    output logic [NUM_CH-1:0]    err_overflow,
    output logic [NUM_CH-1:0]    err_framing
);

    logic [NUM_CH-1:0] rd_en_s, fifo_sop_s, fifo_eop_s, fifo_nempty_s, frame_avail_s;
    logic [DW-1:0]     fifo_data_s [NUM_CH];

    arb_state_e     state_q, state_d;
    logic [CHW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, pick_s;
    logic [CHW:0]   cand_s;
    logic           any_s, rd_fire_s;
    logic           out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        trb_frame_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .wr_valid     (st_valid_in[i]),
            .wr_sop       (st_sop_in[i]),
            .wr_eop       (st_eop_in[i]),
            .wr_data      (st_data_in[i*DW +: DW]),
            .wr_ready     (st_ready_out[i]),
            .rd_en        (rd_en_s[i]),
            .rd_data      (fifo_data_s[i]),
            .rd_sop       (fifo_sop_s[i]),
            .rd_eop       (fifo_eop_s[i]),
            .rd_nempty    (fifo_nempty_s[i]),
            .frame_avail  (frame_avail_s[i]),
            .err_overflow (err_overflow[i]),
            .err_framing  (err_framing[i])
        );
    end

    // Search order starts just after the last served channel and wraps.
    always_comb begin
        any_s  = 1'b0;
        pick_s = last_grant_q;
        cand_s = {(CHW+1){1'b0}};
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_s = {1'b0, last_grant_q} + (CHW+1)'(k);
            if (cand_s >= (CHW+1)'(NUM_CH)) begin
                cand_s = cand_s - (CHW+1)'(NUM_CH);
            end else begin
                cand_s = cand_s;
            end
            if (!any_s && frame_avail_s[cand_s[CHW-1:0]]) begin
                any_s  = 1'b1;
                pick_s = cand_s[CHW-1:0];
            end else begin
                any_s  = any_s;
            end
        end
    end

    always_comb begin
        rd_fire_s = (state_q == ST_XFER) && (!out_valid_q || st_ready_in)
                    && fifo_nempty_s[grant_q];
        rd_en_s   = {NUM_CH{1'b0}};
        if (rd_fire_s) begin
            rd_en_s[grant_q] = 1'b1;
        end else begin
            rd_en_s = {NUM_CH{1'b0}};
        end

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    grant_d = pick_s;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Leave as soon as the eop word moves into the output register, so the
            // next arbitration overlaps that beat and costs a single output bubble.
            ST_XFER: begin
                if (rd_fire_s && fifo_eop_s[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (rd_fire_s) begin
            out_valid_d = 1'b1;
            out_sop_d   = fifo_sop_s[grant_q];
            out_eop_d   = fifo_eop_s[grant_q];
            out_data_d  = fifo_data_s[grant_q];
            out_ch_d    = grant_q;
        end else if (st_ready_in) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= {CHW{1'b0}};
            last_grant_q <= CHW'(NUM_CH - 1);
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_data_q   <= {DW{1'b0}};
            out_ch_q     <= {CHW{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
        end
    end

    assign st_valid_out = out_valid_q;
    assign st_sop_out   = out_sop_q;
    assign st_eop_out   = out_eop_q;
    assign st_data_out  = out_data_q;
    assign st_ch_out    = out_ch_q;

endmodule
